sprite_drawreq_gen: RTL and testbench

Per-object drawing-request generator for the VGA path: it compares the current scan pixel against a sprite's on-screen rectangle, fetches the sprite's pixel from an external synchronous bitmap ROM, and produces a `drawRequest`/`RGBout` pair. The pair feeds one input of the priority drawing-request mux. It also handles per-frame position latching, animation frame stepping and a hit-blink state machine, so game logic only supplies the position and event pulses.

---
 rtl/sprite_drawreq_gen_if.sv | 13 +
 rtl/sprite_drawreq_gen.sv | 208 ++++++++++++++++++++
 tb/tb_sprite_drawreq_gen.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_drawreq_gen_if.sv
// Sprite bitmap ROM bus.
//   romAddr : address {frame, offY, offX}, driven by the draw-request generator
//   romData : synchronous ROM read data, valid one clock after romAddr
// master = draw-request generator, slave = bitmap ROM.
interface sprite_drawreq_gen_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] romAddr;
   logic [7:0]        romData;

   modport master (output romAddr, input  romData);
   modport slave  (input  romAddr, output romData);
endinterface

// File: rtl/sprite_drawreq_gen.sv
// Per-object drawing-request generator for the VGA path.
// Compares the scan pixel against the sprite rectangle latched at the start of
// each video frame, fetches the sprite pixel from an external synchronous ROM,
// and produces drawRequest/RGBout three clocks after the pixel. It also steps
// the animation frame and runs the hit-blink state machine.
//
// Ports:
//   clk, resetN           pixel clock, asynchronous active-low reset
//   pixelX, pixelY        current scan position
//   startOfFrame          one-cycle pulse per video frame
//   topLeftX, topLeftY    requested sprite position (latched on startOfFrame)
//   enable                sprite visible
//   hit                   starts / restarts a blink
//   mirror                horizontal mirror (only with SPRITE_MIRROR_EN)
//   rom                   bitmap ROM bus (master side)
//   drawRequest, RGBout   draw decision and colour
//   blinking              blink FSM is active
//
// Build option: define SPRITE_MIRROR_EN to add the mirror input.
//
// Blink FSM states:
//   state   | meaning
//   ST_IDLE | no blink in progress, sprite drawn normally
//   ST_ON   | blink in progress, visible phase
//   ST_OFF  | blink in progress, hidden phase (drawRequest suppressed)
module sprite_drawreq_gen #(
   parameter int         SPRITE_W     = 32,
   parameter int         SPRITE_H     = 32,
   parameter int         FRAMES       = 4,
   parameter int         FRAME_DIV    = 8,
   parameter int         BLINK_FRAMES = 64,
   parameter logic [7:0] TRANSPARENT  = 8'hFF
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic [10:0] topLeftX,
   input  logic [10:0] topLeftY,
   input  logic        enable,
   input  logic        hit,
`ifdef SPRITE_MIRROR_EN
   input  logic        mirror,
`endif
   sprite_drawreq_gen_if.master rom,
   output logic        drawRequest,
   output logic [7:0]  RGBout,
   output logic        blinking
);

   localparam int OFFX_W  = $clog2(SPRITE_W);
   localparam int OFFY_W  = $clog2(SPRITE_H);
   localparam int FRAME_W = $clog2(FRAMES);
   localparam int ADDR_W  = FRAME_W + OFFY_W + OFFX_W;
   localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } blink_state_e;

   logic [10:0]        pos_x_q, pos_x_d;
   logic [10:0]        pos_y_q, pos_y_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic               inside_s1_q, inside_s1_d;
   logic               en_s1_q, en_s1_d;
   logic               inside_s2_q, inside_s2_d;
   logic               en_s2_q, en_s2_d;
   logic               draw_q, draw_d;
   logic [7:0]         rgb_q, rgb_d;
`ifdef SPRITE_MIRROR_EN
   logic               mirror_q, mirror_d;
`endif

   blink_state_e       state_q;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic [1:0]         phase_q;
   logic               blinking_q;

   // Inside test is done at 12 bits so a sprite near X=2047 does not wrap.
   logic [11:0]        pix_x_ext, pix_y_ext, pos_x_ext, pos_y_ext;
   logic [OFFX_W-1:0]  off_x;
   logic [OFFY_W-1:0]  off_y;

   always_comb begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      frame_d = frame_q;
      div_d   = div_q;
`ifdef SPRITE_MIRROR_EN
      mirror_d = mirror_q;
`endif
      if (startOfFrame) begin
         pos_x_d = topLeftX;
         pos_y_d = topLeftY;
`ifdef SPRITE_MIRROR_EN
         mirror_d = mirror;
`endif
         if (div_q == DIV_W'(FRAME_DIV - 1)) begin
            div_d   = '0;
            frame_d = frame_q + 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      // Stage 1 uses the position latched before this edge, so a
      // startOfFrame on a visible pixel still draws with the old position.
      pix_x_ext = {1'b0, pixelX};
      pix_y_ext = {1'b0, pixelY};
      pos_x_ext = {1'b0, pos_x_q};
      pos_y_ext = {1'b0, pos_y_q};
      inside_s1_d = (pix_x_ext >= pos_x_ext) && (pix_x_ext < pos_x_ext + 12'(SPRITE_W)) &&
                    (pix_y_ext >= pos_y_ext) && (pix_y_ext < pos_y_ext + 12'(SPRITE_H));
      en_s1_d = enable;

      off_x = OFFX_W'(pixelX - pos_x_q);
      off_y = OFFY_W'(pixelY - pos_y_q);
`ifdef SPRITE_MIRROR_EN
      if (mirror_q) begin
         off_x = OFFX_W'(SPRITE_W - 1) - off_x;
      end
`endif
      rom_addr_d = {frame_q, off_y, off_x};

      // Stage 2: ROM registers romData, flags ride alongside.
      inside_s2_d = inside_s1_q;
      en_s2_d     = en_s1_q;

      // Stage 3: blink state is taken as it is now, not when the pixel entered.
      draw_d = inside_s2_q && en_s2_q && (state_q != ST_OFF) && (rom.romData != TRANSPARENT);
      rgb_d  = draw_d ? rom.romData : 8'h00;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         frame_q     <= '0;
         div_q       <= '0;
         rom_addr_q  <= '0;
         inside_s1_q <= 1'b0;
         en_s1_q     <= 1'b0;
         inside_s2_q <= 1'b0;
         en_s2_q     <= 1'b0;
         draw_q      <= 1'b0;
         rgb_q       <= '0;
`ifdef SPRITE_MIRROR_EN
         mirror_q    <= 1'b0;
`endif
      end else begin
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         frame_q     <= frame_d;
         div_q       <= div_d;
         rom_addr_q  <= rom_addr_d;
         inside_s1_q <= inside_s1_d;
         en_s1_q     <= en_s1_d;
         inside_s2_q <= inside_s2_d;
         en_s2_q     <= en_s2_d;
         draw_q      <= draw_d;
         rgb_q       <= rgb_d;
`ifdef SPRITE_MIRROR_EN
         mirror_q    <= mirror_d;
`endif
      end
   end

   // Blink FSM. hit has priority over everything, including the terminal
   // startOfFrame. The phase counter toggles ON/OFF every 4 video frames.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         blink_cnt_q <= '0;
         phase_q     <= '0;
         blinking_q  <= 1'b0;
      end else if (hit) begin
         state_q     <= ST_ON;
         blink_cnt_q <= '0;
         phase_q     <= '0;
         blinking_q  <= 1'b1;
      end else if (startOfFrame && (state_q != ST_IDLE)) begin
         if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
            state_q     <= ST_IDLE;
            blink_cnt_q <= '0;
            phase_q     <= '0;
            blinking_q  <= 1'b0;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
            phase_q     <= phase_q + 1'b1;
            if (phase_q == 2'd3) begin
               state_q <= (state_q == ST_ON) ? ST_OFF : ST_ON;
            end
         end
      end
   end

   assign rom.romAddr = rom_addr_q;
   assign drawRequest = draw_q;
   assign RGBout      = rgb_q;
   assign blinking    = blinking_q;

endmodule

// File: tb/tb_sprite_drawreq_gen.sv
module tb_sprite_drawreq_gen;

   localparam int SW    = 32;
   localparam int SH    = 32;
   localparam int NFR   = 4;
   localparam int FDIV  = 8;
   localparam int BLINK = 64;

   logic        clk = 1'b0;
   logic        resetN;
   logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
   logic        startOfFrame, enable, hit;
   logic        drawRequest, blinking;
   logic [7:0]  RGBout;
`ifdef SPRITE_MIRROR_EN
   logic        mirror;
`endif

   sprite_drawreq_gen_if #(.ADDR_W(12)) rom_if ();

   sprite_drawreq_gen dut (
      .clk          (clk),
      .resetN       (resetN),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .startOfFrame (startOfFrame),
      .topLeftX     (topLeftX),
      .topLeftY     (topLeftY),
      .enable       (enable),
      .hit          (hit),
`ifdef SPRITE_MIRROR_EN
      .mirror       (mirror),
`endif
      .rom          (rom_if.master),
      .drawRequest  (drawRequest),
      .RGBout       (RGBout),
      .blinking     (blinking)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:4095];
   always @(posedge clk) rom_if.romData <= mem[rom_if.romAddr];

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state
   int m_posx, m_posy, m_sofs, m_since;
   bit m_mirror;
   bit p_ok [0:1];
   int p_addr [0:1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_posx = 0; m_posy = 0; m_sofs = 0; m_since = -1; m_mirror = 0;
      p_ok[0] = 0; p_ok[1] = 0; p_addr[0] = 0; p_addr[1] = 0;
   endtask

   // One clock: predict, advance the model, clock, compare.
   task automatic step();
      int px, py, ox, oy, addr;
      bit ins, vis, ed;
      logic [7:0] d, er;
      px  = int'(pixelX);
      py  = int'(pixelY);
      ins = (px >= m_posx) && (px < m_posx + SW) && (py >= m_posy) && (py < m_posy + SH);
      ox  = (px - m_posx) & (SW - 1);
      if (m_mirror) ox = SW - 1 - ox;
      oy  = (py - m_posy) & (SH - 1);
      addr = ((m_sofs / FDIV) % NFR) * SW * SH + oy * SW + ox;
      vis = !(m_since >= 0 && ((m_since / 4) % 2) == 1);
      d   = mem[p_addr[1]];
      ed  = p_ok[1] && vis && (d != 8'hFF);
      er  = ed ? d : 8'h00;
      p_ok[1] = p_ok[0]; p_addr[1] = p_addr[0];
      p_ok[0] = ins && enable; p_addr[0] = addr;
      if (startOfFrame) begin
         m_posx = int'(topLeftX);
         m_posy = int'(topLeftY);
`ifdef SPRITE_MIRROR_EN
         m_mirror = mirror;
`endif
         m_sofs++;
      end
      if (hit) m_since = 0;
      else if (startOfFrame && m_since >= 0) begin
         m_since++;
         if (m_since >= BLINK) m_since = -1;
      end
      @(posedge clk); #1;
      chk("model_addr", 32'(rom_if.romAddr), 32'(addr));
      chk("model_draw", 32'(drawRequest), 32'(ed));
      chk("model_rgb", 32'(RGBout), 32'(er));
      chk("model_blink", 32'(blinking), 32'(m_since >= 0));
      startOfFrame = 1'b0;
      hit = 1'b0;
   endtask

   task automatic pix(input int x, input int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
   endtask

   task automatic sof_to(input int x, input int y);
      topLeftX = 11'(x); topLeftY = 11'(y); startOfFrame = 1'b1;
      step();
   endtask

   typedef struct {
      int         px;
      int         py;
      bit         en;
      int         exp_addr;
      bit         exp_draw;
      logic [7:0] exp_rgb;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int px;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) mem[i] = 8'hFF;
      end
      for (int f = 0; f < NFR; f++) begin
         mem[f * 1024]     = 8'h3A;
         mem[f * 1024 + 5] = 8'h42;
      end
      mem[0] = 8'h1C; mem[1] = 8'h55; mem[33] = 8'hFF; mem[1023] = 8'hA7;

      tbl[0] = '{100, 50, 1'b1, 0,    1'b1, 8'h1C};
      tbl[1] = '{99,  50, 1'b1, 31,   1'b0, 8'h00};
      tbl[2] = '{132, 50, 1'b1, 0,    1'b0, 8'h00};
      tbl[3] = '{101, 51, 1'b1, 33,   1'b0, 8'h00};
      tbl[4] = '{101, 50, 1'b0, 1,    1'b0, 8'h00};
      tbl[5] = '{101, 50, 1'b1, 1,    1'b1, 8'h55};
      tbl[6] = '{131, 81, 1'b1, 1023, 1'b1, 8'hA7};
      tbl[7] = '{100, 82, 1'b1, 0,    1'b0, 8'h00};

      resetN = 1'b0; startOfFrame = 1'b0; hit = 1'b0; enable = 1'b1;
      topLeftX = '0; topLeftY = '0; pix(0, 0);
`ifdef SPRITE_MIRROR_EN
      mirror = 1'b0;
`endif
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_draw", 32'(drawRequest), 0);
      chk("reset_rgb", 32'(RGBout), 0);
      chk("reset_blink", 32'(blinking), 0);
      chk("reset_addr", 32'(rom_if.romAddr), 0);
      resetN = 1'b1;

      // Directed table: position (100,50), frame 0
      pix(600, 600);
      sof_to(100, 50);
      for (int i = 0; i < 8; i++) begin
         pix(tbl[i].px, tbl[i].py); enable = tbl[i].en;
         step();
         chk("tbl_addr", 32'(rom_if.romAddr), 32'(tbl[i].exp_addr));
         pix(0, 0); enable = 1'b1;
         step();
         chk("tbl_latency", 32'(drawRequest), 0);
         step();
         chk("tbl_draw", 32'(drawRequest), 32'(tbl[i].exp_draw));
         chk("tbl_rgb", 32'(RGBout), 32'(tbl[i].exp_rgb));
      end

      // Right-edge sprite must not wrap to column 0
      sof_to(2040, 50);
      pix(2045, 50); step(); pix(0, 0); step(); step();
      chk("wrap_edge", 32'(drawRequest), 1);
      pix(5, 50); step(); pix(0, 0); step(); step();
      chk("wrap_col5", 32'(drawRequest), 0);

      // Mid-frame position change is ignored until the next frame
      sof_to(100, 50);
      topLeftX = 11'd200;
      pix(100, 50); step(); pix(0, 0); step(); step();
      chk("latch_hold", 32'(drawRequest), 1);
      sof_to(200, 50);
      pix(200, 50); step(); pix(0, 0); step(); step();
      chk("latch_new", 32'(drawRequest), 1);

      // Asynchronous reset mid-line
      hit = 1'b1; pix(200, 50); step();
      pix(201, 50); step();
      pix(202, 50); step();
      chk("pre_reset_draw", 32'(drawRequest), 1);
      #2 resetN = 1'b0;
      #1;
      chk("midrst_draw", 32'(drawRequest), 0);
      chk("midrst_rgb", 32'(RGBout), 0);
      chk("midrst_blink", 32'(blinking), 0);
      chk("midrst_addr", 32'(rom_if.romAddr), 0);
      @(posedge clk); #1;
      resetN = 1'b1;
      model_reset();
      pix(0, 0); step();
      pix(600, 600); step();
      chk("post_reset_lat", 32'(drawRequest), 0);
      step();
      chk("post_reset_draw", 32'(drawRequest), 1);
      chk("post_reset_rgb", 32'(RGBout), 32'h1C);

      // Animation: 32 frames -> 0,1,2,3,0
      for (int k = 1; k <= 32; k++) begin
         pix(600, 600);
         sof_to(100, 50);
         pix(100, 50); step();
         chk("anim_frame", 32'(rom_if.romAddr >> 10), 32'((k / FDIV) % NFR));
         if (k == 8) chk("anim_f1_addr", 32'(rom_if.romAddr), 1024);
      end

      // Blink: suppressed in frames 4-7, 12-15, ...; ends after 64 frames
      pix(600, 600); hit = 1'b1; step();
      chk("blink_start", 32'(blinking), 1);
      for (int f = 1; f <= 70; f++) begin
         pix(600, 600);
         sof_to(100, 50);
         pix(100, 50); step(); pix(600, 600); step(); step();
         chk("blink_vis", 32'(drawRequest), 32'((f >= BLINK) || ((f / 4) % 2 == 0)));
         chk("blink_flag", 32'(blinking), 32'(f < BLINK));
      end

      // Second hit at frame 30 restarts the count
      hit = 1'b1; step();
      for (int f = 1; f <= 30; f++) sof_to(100, 50);
      hit = 1'b1; step();
      for (int f = 1; f <= 64; f++) begin
         sof_to(100, 50);
         if (f == 63) chk("rehit_63", 32'(blinking), 1);
         if (f == 64) chk("rehit_64", 32'(blinking), 0);
      end

      // hit coinciding with the terminal startOfFrame wins
      hit = 1'b1; step();
      for (int f = 1; f <= 63; f++) sof_to(100, 50);
      hit = 1'b1; sof_to(100, 50);
      chk("hit_wins", 32'(blinking), 1);
      for (int f = 1; f <= 4; f++) sof_to(100, 50);
      chk("hit_wins_cont", 32'(blinking), 1);
      pix(100, 50); step(); pix(600, 600); step(); step();
      chk("hit_wins_off", 32'(drawRequest), 0);

`ifdef SPRITE_MIRROR_EN
      mirror = 1'b1;
      sof_to(100, 50);
      pix(100, 50); step();
      chk("mirror_addr", 32'(rom_if.romAddr & 12'h1F), 31);
      mirror = 1'b0;
      sof_to(100, 50);
`endif

      // Randomized run against the reference model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 59) == 0) begin
            startOfFrame = 1'b1;
            if ($urandom_range(0, 3) == 0) topLeftX = 11'($urandom_range(2030, 2047));
            else topLeftX = 11'($urandom_range(0, 1900));
            topLeftY = 11'($urandom_range(0, 1000));
`ifdef SPRITE_MIRROR_EN
            mirror = 1'($urandom_range(0, 1));
`endif
         end
         if ($urandom_range(0, 399) == 0) hit = 1'b1;
         px = m_posx + int'($urandom_range(0, 80)) - 40;
         if (px < 0) px = 0;
         if (px > 2047) px = 2047;
         pixelX = 11'(px);
         px = m_posy + int'($urandom_range(0, 80)) - 40;
         if (px < 0) px = 0;
         if (px > 2047) px = 2047;
         pixelY = 11'(px);
         enable = ($urandom_range(0, 7) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
